core_arbiter: RTL and testbench



---
 rtl/core_arbiter.sv | 160 ++++++++++++++++
 tb/tb_core_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_arbiter.sv
// core_arbiter: round-robin 2:1 arbiter with request locking that shares one
// downstream core_if slave between two core_if masters. An ID FIFO records
// which master owns each outstanding transaction so that the in-order
// responses are routed back to the master that issued them.
module core_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    // requester 0
    input  logic        m0_req,
    output logic        m0_gnt,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    // requester 1
    input  logic        m1_req,
    output logic        m1_gnt,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    // shared slave
    output logic        s_req,
    input  logic        s_gnt,
    output logic        s_we,
    output logic [3:0]  s_be,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_rvalid,
    input  logic [31:0] s_rdata,
    input  logic        s_err,
    // response arrived with nothing outstanding
    output logic        resp_err
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

    // FIFO pointer advance, wrapping modulo the FIFO depth
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == PTR_LAST) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    logic          lock_r;
    logic          lock_id_r;
    logic          last_r;
    logic          fifo_r [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] cnt_r;
    logic          rst_q_r;

    logic          sel_s;
    logic          sel_req_s;
    logic          full_s;
    logic          empty_s;
    logic          hold_s;
    logic          accept_s;
    logic          pop_s;
    logic          head_s;

    // Pick the master to forward: locked owner, single requester, or the one not served last
    always_comb begin
        sel_s = last_r;
        if (lock_r) begin
            sel_s = lock_id_r;
        end else if (m0_req && m1_req) begin
            sel_s = ~last_r;
        end else if (m0_req) begin
            sel_s = 1'b0;
        end else if (m1_req) begin
            sel_s = 1'b1;
        end else begin
            sel_s = last_r;
        end
    end

    // Forward the selected request, route grant and responses; outputs are
    // quiet in the reset cycle and the cycle right after it
    always_comb begin
        hold_s    = rst | rst_q_r;
        full_s    = (cnt_r == CNT_MAX);
        empty_s   = (cnt_r == {CW{1'b0}});
        sel_req_s = sel_s ? m1_req : m0_req;
        s_req     = sel_req_s & ~full_s & ~hold_s;
        s_we      = sel_s ? m1_we    : m0_we;
        s_be      = sel_s ? m1_be    : m0_be;
        s_addr    = sel_s ? m1_addr  : m0_addr;
        s_wdata   = sel_s ? m1_wdata : m0_wdata;
        accept_s  = s_req & s_gnt;
        m0_gnt    = accept_s & ~sel_s;
        m1_gnt    = accept_s & sel_s;
        head_s    = fifo_r[rd_ptr_r];
        pop_s     = s_rvalid & ~empty_s & ~hold_s;
        m0_rvalid = pop_s & ~head_s;
        m1_rvalid = pop_s & head_s;
        m0_err    = pop_s & ~head_s & s_err;
        m1_err    = pop_s & head_s & s_err;
        m0_rdata  = s_rdata;
        m1_rdata  = s_rdata;
        resp_err  = s_rvalid & empty_s & ~hold_s;
    end

    // Delayed reset marker used to keep outputs quiet one cycle after reset
    always_ff @(posedge clk) begin
        rst_q_r <= rst;
    end

    // Arbitration state, lock, ID FIFO and outstanding counter
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_r    <= 1'b0;
            lock_id_r <= 1'b0;
            last_r    <= 1'b1;
            wr_ptr_r  <= {PW{1'b0}};
            rd_ptr_r  <= {PW{1'b0}};
            cnt_r     <= {CW{1'b0}};
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_r[i] <= 1'b0;
            end
        end else begin
            if (accept_s) begin
                fifo_r[wr_ptr_r] <= sel_s;
                wr_ptr_r         <= ptr_next(wr_ptr_r);
                last_r           <= sel_s;
                lock_r           <= 1'b0;
            end else if (s_req && !lock_r) begin
                lock_r    <= 1'b1;
                lock_id_r <= sel_s;
            end else begin
                lock_r <= lock_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({accept_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: tb/tb_core_arbiter.sv
// Directed bench for core_arbiter: stimulus pushes expected grants and
// responses into queues; independent monitors pop and compare them.
module tb_core_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_gnt, m0_we, m0_rvalid, m0_err;
    logic [3:0]  m0_be;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_gnt, m1_we, m1_rvalid, m1_err;
    logic [3:0]  m1_be;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        s_req, s_gnt, s_we, s_rvalid, s_err;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        id;
        logic [31:0] addr;
        logic        we;
    } gexp_t;

    typedef struct {
        logic [1:0]  kind;   // 0: m0, 1: m1, 2: spurious
        logic [31:0] data;
        logic        err;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];

    always #5 clk = ~clk;

    core_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_we(m0_we), .m0_be(m0_be),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_we(m1_we), .m1_be(m1_be),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_req(s_req), .s_gnt(s_gnt), .s_we(s_we), .s_be(s_be),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rvalid(s_rvalid),
        .s_rdata(s_rdata), .s_err(s_err),
        .resp_err(resp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic [31:0] a0,
                         input logic r1, input logic [31:0] a1,
                         input logic g, input logic rv,
                         input logic [31:0] rd, input logic er);
        m0_req = r0; m0_addr = a0; m0_wdata = ~a0;
        m1_req = r1; m1_addr = a1; m1_wdata = ~a1;
        s_gnt = g; s_rvalid = rv; s_rdata = rd; s_err = er;
    endtask

    task automatic eg(input logic id, input logic [31:0] addr, input logic we);
        gexp_t e;
        e.id = id; e.addr = addr; e.we = we;
        gq.push_back(e);
    endtask

    task automatic er(input logic [1:0] kind, input logic [31:0] data, input logic err);
        rexp_t e;
        e.kind = kind; e.data = data; e.err = err;
        rq.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string name);
        chk(name, {24'h0, s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid,
                   m0_err, m1_err, resp_err}, 32'h0);
    endtask

    // Grant monitor: every accepted request must match the next expected grant
    always @(negedge clk) begin
        if (s_req && s_gnt) begin
            if (gq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_grant: addr %h with no grant expected", s_addr);
            end else begin
                gexp_t e;
                e = gq.pop_front();
                chk("grant_id", {30'h0, m0_gnt, m1_gnt}, e.id ? 32'h1 : 32'h2);
                chk("grant_addr", s_addr, e.addr);
                chk("grant_wdata", s_wdata, ~e.addr);
                chk("grant_we", {31'h0, s_we}, {31'h0, e.we});
            end
        end else if (m0_gnt || m1_gnt) begin
            checks++; errors++;
            $display("FAIL stray_gnt: m0_gnt=%b m1_gnt=%b without accept", m0_gnt, m1_gnt);
        end
    end

    // Response monitor: every response event must match the next expected response
    always @(negedge clk) begin
        if (m0_rvalid || m1_rvalid || resp_err) begin
            if (rq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_resp: rv0=%b rv1=%b resp_err=%b",
                         m0_rvalid, m1_rvalid, resp_err);
            end else begin
                rexp_t e;
                logic [31:0] want;
                e = rq.pop_front();
                want = (e.kind == 2'd0) ? 32'h1 : ((e.kind == 2'd1) ? 32'h2 : 32'h4);
                chk("resp_route", {29'h0, resp_err, m1_rvalid, m0_rvalid}, want);
                chk("resp_err_bits", {30'h0, m1_err, m0_err},
                    (e.err && e.kind == 2'd0) ? 32'h1 :
                    ((e.err && e.kind == 2'd1) ? 32'h2 : 32'h0));
                if (e.kind != 2'd2) begin
                    chk("resp_rdata0", m0_rdata, e.data);
                    chk("resp_rdata1", m1_rdata, e.data);
                end
            end
        end else if (m0_err || m1_err) begin
            checks++; errors++;
            $display("FAIL stray_err: m0_err=%b m1_err=%b", m0_err, m1_err);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m0_we = 1'b0; m1_we = 1'b0; m0_be = 4'hF; m1_be = 4'hF;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        next_cycle();

        // reset cycle with requests and grant present: outputs stay quiet
        rst = 1'b1;
        drive(1'b1, 32'h10, 1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk); chk_quiet("reset_cycle_quiet");
        next_cycle();
        // first cycle after reset: still quiet
        rst = 1'b0;
        @(negedge clk); chk_quiet("post_reset_quiet");
        next_cycle();

        // tie round-robin: m0, m1, m0, m1 with responses one cycle later
        drive(1'b1, 32'h10, 1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 1'b0);
        eg(1'b0, 32'h10, 1'b0);
        next_cycle();
        drive(1'b1, 32'h14, 1'b1, 32'h20, 1'b1, 1'b1, 32'hA0, 1'b0);
        eg(1'b1, 32'h20, 1'b0); er(2'd0, 32'hA0, 1'b0);
        next_cycle();
        // simultaneous accept (m0) and response (earlier m1 read)
        drive(1'b1, 32'h14, 1'b1, 32'h24, 1'b1, 1'b1, 32'hA1, 1'b0);
        eg(1'b0, 32'h14, 1'b0); er(2'd1, 32'hA1, 1'b0);
        next_cycle();
        drive(1'b1, 32'h18, 1'b1, 32'h24, 1'b1, 1'b1, 32'hA2, 1'b0);
        eg(1'b1, 32'h24, 1'b0); er(2'd0, 32'hA2, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA3, 1'b0);
        er(2'd1, 32'hA3, 1'b0);
        @(negedge clk); chk("idle_no_req", {31'h0, s_req}, 32'h0);
        next_cycle();

        // lock: m1 waits three cycles, m0 arrives meanwhile and must not steal
        drive(1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk); chk("lock_addr0", s_addr, 32'h100);
        next_cycle();
        for (int i = 1; i < 3; i++) begin
            drive(1'b1, 32'h200, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
            @(negedge clk);
            chk("lock_addr_held", s_addr, 32'h100);
            chk("lock_req_held", {31'h0, s_req}, 32'h1);
            next_cycle();
        end
        drive(1'b1, 32'h200, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0);
        eg(1'b1, 32'h100, 1'b0);
        next_cycle();
        drive(1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        eg(1'b0, 32'h200, 1'b0);
        next_cycle();

        // full: two outstanding, third request blocked even when a pop occurs
        drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk); chk("full_no_req", {31'h0, s_req}, 32'h0);
        next_cycle();
        drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 1'b1, 32'hB0, 1'b0);
        er(2'd1, 32'hB0, 1'b0);
        @(negedge clk); chk("full_pop_no_req", {31'h0, s_req}, 32'h0);
        next_cycle();
        drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 1'b1, 32'hB1, 1'b0);
        eg(1'b0, 32'h300, 1'b0); er(2'd0, 32'hB1, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hB2, 1'b0);
        er(2'd0, 32'hB2, 1'b0);
        next_cycle();

        // error response for an m1 write, then a spurious response
        m1_we = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 32'h400, 1'b1, 1'b0, 32'h0, 1'b0);
        eg(1'b1, 32'h400, 1'b1);
        next_cycle();
        m1_we = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC0, 1'b1);
        er(2'd1, 32'hC0, 1'b1);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC1, 1'b0);
        er(2'd2, 32'hC1, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk); chk("resp_err_pulse_end", {31'h0, resp_err}, 32'h0);
        next_cycle();

        // reset mid-flight: one outstanding m0 read, m1 locked
        drive(1'b1, 32'h504, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        eg(1'b0, 32'h504, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b1, 32'h508, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk); chk("pre_reset_lock_addr", s_addr, 32'h508);
        next_cycle();
        rst = 1'b1;
        drive(1'b1, 32'h50C, 1'b1, 32'h508, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk); chk_quiet("midflight_reset_quiet");
        next_cycle();
        rst = 1'b0;
        @(negedge clk); chk_quiet("midflight_post_reset_quiet");
        next_cycle();
        // first tie after reset goes to m0 despite the old m1 lock
        eg(1'b0, 32'h50C, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hD0, 1'b0);
        er(2'd0, 32'hD0, 1'b0);
        next_cycle();
        // old outstanding entry was discarded: this response is spurious
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hD1, 1'b0);
        er(2'd2, 32'hD1, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        next_cycle();
        next_cycle();

        chk("grant_queue_drained", gq.size(), 32'h0);
        chk("resp_queue_drained", rq.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
